// File: rtl/alu.sv
// Execute-stage ALU: operand-B select (bus_b or imm), 16 integer ops on N-bit
// operands, combinational result/flags plus a registered copy for the MEM stage.
module alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         alu_src,
  input  logic [N-1:0] bus_a,
  input  logic [N-1:0] bus_b,
  input  logic [N-1:0] imm,
  input  logic [3:0]   alu_ctrl,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic [N-1:0] q_result,
  output logic         q_overflow,
  output logic         q_zero
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDU = 4'h1,
    OP_SUB  = 4'h2,
    OP_SUBU = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SLL  = 4'h7,
    OP_SRL  = 4'h8,
    OP_SRA  = 4'h9,
    OP_SEQ  = 4'hA,
    OP_SNE  = 4'hB,
    OP_SLT  = 4'hC,
    OP_SGT  = 4'hD,
    OP_SLE  = 4'hE,
    OP_SGE  = 4'hF
  } alu_op_e;

  logic [N-1:0] w_opb;
  logic [N-1:0] w_sum;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_result;
  logic [4:0]   w_shamt;
  logic         w_eq;
  logic         w_lt;
  logic         w_add_ovf;
  logic         w_sub_ovf;
  logic         w_overflow;

  assign w_opb   = alu_src ? imm : bus_b;
  assign w_sum   = bus_a + w_opb;
  assign w_diff  = bus_a - w_opb;
  assign w_shamt = w_opb[4:0];
  assign w_eq    = (bus_a == w_opb);
  assign w_lt    = ($signed(bus_a) < $signed(w_opb));

  // Signed overflow from sign bits only; the result itself is always the wrapped value.
  assign w_add_ovf = (bus_a[N-1] == w_opb[N-1]) && (w_sum[N-1]  != bus_a[N-1]);
  assign w_sub_ovf = (bus_a[N-1] != w_opb[N-1]) && (w_diff[N-1] != bus_a[N-1]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_result   = '0;
    w_overflow = 1'b0;
    case (alu_op_e'(alu_ctrl))
      OP_ADD:  begin
        w_result   = w_sum;
        w_overflow = w_add_ovf;
      end
      OP_ADDU: w_result = w_sum;
      OP_SUB:  begin
        w_result   = w_diff;
        w_overflow = w_sub_ovf;
      end
      OP_SUBU: w_result = w_diff;
      OP_AND:  w_result = bus_a & w_opb;
      OP_OR:   w_result = bus_a | w_opb;
      OP_XOR:  w_result = bus_a ^ w_opb;
      OP_SLL:  w_result = bus_a << w_shamt;
      OP_SRL:  w_result = bus_a >> w_shamt;
      OP_SRA:  w_result = $unsigned($signed(bus_a) >>> w_shamt);
      OP_SEQ:  w_result = {{(N-1){1'b0}}, w_eq};
      OP_SNE:  w_result = {{(N-1){1'b0}}, ~w_eq};
      OP_SLT:  w_result = {{(N-1){1'b0}}, w_lt};
      OP_SGT:  w_result = {{(N-1){1'b0}}, ~w_lt & ~w_eq};
      OP_SLE:  w_result = {{(N-1){1'b0}}, w_lt | w_eq};
      OP_SGE:  w_result = {{(N-1){1'b0}}, ~w_lt};
      default: ;
    endcase
  end

  assign result   = w_result;
  assign overflow = w_overflow;
  assign zero     = (w_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      q_result   <= '0;
      q_overflow <= 1'b0;
      q_zero     <= 1'b0;
    end else if (en) begin
      q_result   <= w_result;
      q_overflow <= w_overflow;
      q_zero     <= (w_result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a 64-bit arithmetic reference model checked every
// negedge, plus directed vectors with literal expectations.
module tb_alu;

  localparam int N = 32;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          alu_src;
  logic [N-1:0]  bus_a, bus_b, imm;
  logic [3:0]    alu_ctrl;
  logic [N-1:0]  result, q_result;
  logic          overflow, zero, q_overflow, q_zero;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  logic [N-1:0] exp_q_result;
  logic         exp_q_overflow;
  logic         exp_q_zero;

  alu #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .alu_src    (alu_src),
    .bus_a      (bus_a),
    .bus_b      (bus_b),
    .imm        (imm),
    .alu_ctrl   (alu_ctrl),
    .result     (result),
    .overflow   (overflow),
    .zero       (zero),
    .q_result   (q_result),
    .q_overflow (q_overflow),
    .q_zero     (q_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed values widened to 64 bits so overflow is a range test.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b_reg,
                                input logic [N-1:0] b_imm, input logic src,
                                input logic [3:0] op,
                                output logic [N-1:0] r, output logic ovf);
    logic [N-1:0] b;
    longint sa, sb, full;
    int sh;
    b    = src ? b_imm : b_reg;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sh   = int'(b[4:0]);
    ovf  = 1'b0;
    r    = '0;
    full = 0;
    case (op)
      4'h0: begin full = sa + sb; r = full[N-1:0]; ovf = (full > MAX_S) || (full < MIN_S); end
      4'h1: begin full = sa + sb; r = full[N-1:0]; end
      4'h2: begin full = sa - sb; r = full[N-1:0]; ovf = (full > MAX_S) || (full < MIN_S); end
      4'h3: begin full = sa - sb; r = full[N-1:0]; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: begin full = longint'({32'h0, a}) * (64'sd1 << sh); r = full[N-1:0]; end
      4'h8: begin full = longint'({32'h0, a}) / (64'sd1 << sh); r = full[N-1:0]; end
      4'h9: begin full = sa >>> sh; r = full[N-1:0]; end
      4'hA: r = (sa == sb) ? 32'd1 : 32'd0;
      4'hB: r = (sa != sb) ? 32'd1 : 32'd0;
      4'hC: r = (sa <  sb) ? 32'd1 : 32'd0;
      4'hD: r = (sa >  sb) ? 32'd1 : 32'd0;
      4'hE: r = (sa <= sb) ? 32'd1 : 32'd0;
      default: r = (sa >= sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Expected registered stage
  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] mr;
    logic         mo;
    if (!rst_n) begin
      exp_q_result   <= '0;
      exp_q_overflow <= 1'b0;
      exp_q_zero     <= 1'b0;
    end else if (en) begin
      model(bus_a, bus_b, imm, alu_src, alu_ctrl, mr, mo);
      exp_q_result   <= mr;
      exp_q_overflow <= mo;
      exp_q_zero     <= (mr == '0);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [N-1:0] mr;
    logic         mo;
    if (run_cmp) begin
      model(bus_a, bus_b, imm, alu_src, alu_ctrl, mr, mo);
      check("cmp_result",     result, mr);
      check("cmp_overflow",   {31'b0, overflow}, {31'b0, mo});
      check("cmp_zero",       {31'b0, zero}, {31'b0, (mr == '0)});
      check("cmp_q_result",   q_result, exp_q_result);
      check("cmp_q_overflow", {31'b0, q_overflow}, {31'b0, exp_q_overflow});
      check("cmp_q_zero",     {31'b0, q_zero}, {31'b0, exp_q_zero});
    end
  end

  // Change inputs just after a negedge, well away from the active edge.
  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] im, input logic src, input logic [3:0] op);
    @(negedge clk);
    #2;
    bus_a = a; bus_b = b; imm = im; alu_src = src; alu_ctrl = op;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    bus_a = 32'd3; bus_b = 32'd4; imm = 32'd0; alu_src = 1'b0; alu_ctrl = 4'h0;
    #1;
    check("reset_q_result",   q_result, 32'd0);
    check("reset_q_zero",     {31'b0, q_zero}, 32'd0);
    check("reset_q_overflow", {31'b0, q_overflow}, 32'd0);
    check("comb_during_reset", result, 32'd7);
    run_cmp = 1'b1;

    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_capture", q_result, 32'd7);

    // Operand select
    apply(32'd1, 32'd5, 32'h10, 1'b0, 4'h0); check("mux_bus_b", result, 32'd6);
    apply(32'd1, 32'd5, 32'h10, 1'b1, 4'h0); check("mux_imm",   result, 32'h11);

    // Overflow
    apply(32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'h0);
    check("add_ovf_res", result, 32'h80000000);
    check("add_ovf",     {31'b0, overflow}, 32'd1);
    apply(32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'h1);
    check("addu_ovf",    {31'b0, overflow}, 32'd0);
    apply(32'h80000000, 32'd1, 32'd0, 1'b0, 4'h2);
    check("sub_ovf_res", result, 32'h7FFFFFFF);
    check("sub_ovf",     {31'b0, overflow}, 32'd1);

    // Shifts
    apply(32'h80000010, 32'd4, 32'd0, 1'b0, 4'h7); check("sll4",    result, 32'h00000100);
    apply(32'h80000010, 32'd4, 32'd0, 1'b0, 4'h8); check("srl4",    result, 32'h08000001);
    apply(32'h80000010, 32'd4, 32'd0, 1'b0, 4'h9); check("sra4",    result, 32'hF8000001);
    apply(32'h80000010, 32'h24, 32'd0, 1'b0, 4'h8); check("srl_b24", result, 32'h08000001);
    apply(32'h80000010, 32'h20, 32'd0, 1'b0, 4'h9); check("sra0",   result, 32'h80000010);

    // Set ops, A=-1, B=1
    apply(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hC); check("slt", result, 32'd1);
    apply(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hD); check("sgt", result, 32'd0);
    apply(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hE); check("sle", result, 32'd1);
    apply(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hF); check("sge", result, 32'd0);
    apply(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hA); check("seq", result, 32'd0);
    apply(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hB); check("sne", result, 32'd1);
    apply(32'd5, 32'd5, 32'd0, 1'b0, 4'h2);
    check("sub_zero_res", result, 32'd0);
    check("sub_zero",     {31'b0, zero}, 32'd1);

    // Enable hold / update
    @(posedge clk); #1;
    check("q_before_hold", {31'b0, q_zero}, 32'd1);
    en = 1'b0;
    apply(32'd3, 32'd4, 32'd0, 1'b0, 4'h0);
    apply(32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'h0);
    @(posedge clk); #1;
    check("hold_q_result", q_result, 32'd0);
    check("hold_q_zero",   {31'b0, q_zero}, 32'd1);
    check("hold_q_ovf",    {31'b0, q_overflow}, 32'd0);
    en = 1'b1;
    @(posedge clk); #1;
    check("upd_q_result", q_result, 32'h80000000);
    check("upd_q_ovf",    {31'b0, q_overflow}, 32'd1);

    // Async reset between edges, held across an edge with en=1
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check("async_rst_q_result", q_result, 32'd0);
    check("async_rst_q_ovf",    {31'b0, q_overflow}, 32'd0);
    @(posedge clk); #1;
    check("rst_held_q_result",  q_result, 32'd0);
    @(negedge clk); #2; rst_n = 1'b1;
    apply(32'd10, 32'd3, 32'd0, 1'b0, 4'h3);
    @(posedge clk); #1;
    check("post_release", q_result, 32'd7);

    // Sweep every op over a few operand pairs, through the model
    for (int v = 0; v < 4; v++) begin
      for (int op = 0; op < 16; op++) begin
        case (v)
          0: apply(32'h12345678, 32'h0F0F0F0F, 32'h00000003, 1'b1, 4'(op));
          1: apply(32'h80000000, 32'h80000000, 32'h0, 1'b0, 4'(op));
          2: apply(32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 4'(op));
          default: apply(32'hDEADBEEF, 32'hAAAAAAAA, 32'hFFFFFFE1, 1'b1, 4'(op));
        endcase
      end
    end

    @(negedge clk); #1;
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
